// File: rtl/data_mem_ctrl_pkg.sv
// rtl/data_mem_ctrl_pkg.sv - size encodings, lane offsets and FSM states for the data RAM sequencer
package data_mem_ctrl_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_BAD  = 2'b11;

   // Big-endian byte offsets: offset 0 is the most significant byte of the word.
   localparam logic [1:0] OFF_0 = 2'd0;
   localparam logic [1:0] OFF_1 = 2'd1;
   localparam logic [1:0] OFF_2 = 2'd2;
   localparam logic [1:0] OFF_3 = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ACC,
      ST_RMW_RD,
      ST_RMW_WR,
      ST_RESP
   } state_t;

endpackage

// File: rtl/data_mem_ctrl_be_lane_unit.sv
// rtl/data_mem_ctrl_be_lane_unit.sv - big-endian sub-word store merge and load extract
module data_mem_ctrl_be_lane_unit
   import data_mem_ctrl_pkg::*;
(
   input  logic [31:0] word,
   input  logic [31:0] store_data,
   input  logic [1:0]  size,
   input  logic [1:0]  offset,
   input  logic        sext,
   output logic [31:0] merged,
   output logic [31:0] loaded
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   // Drop the right-justified store data into its lane, keep the other bytes of the old word
   always_comb begin
      merged = store_data;
      if (size == SZ_BYTE) begin
         case (offset)
            OFF_0: merged = {store_data[7:0], word[23:0]};
            OFF_1: merged = {word[31:24], store_data[7:0], word[15:0]};
            OFF_2: merged = {word[31:16], store_data[7:0], word[7:0]};
            OFF_3: merged = {word[31:8], store_data[7:0]};
         endcase
      end else if (size == SZ_HALF) begin
         merged = offset[1] ? {word[31:16], store_data[15:0]} : {store_data[15:0], word[15:0]};
      end
   end

   // Pick the addressed lane out of the word and right-justify it with zero or sign fill
   always_comb begin
      lane_b = word[7:0];
      case (offset)
         OFF_0: lane_b = word[31:24];
         OFF_1: lane_b = word[23:16];
         OFF_2: lane_b = word[15:8];
         OFF_3: lane_b = word[7:0];
      endcase
      lane_h = offset[1] ? word[15:0] : word[31:16];
      loaded = word;
      if (size == SZ_BYTE) begin
         loaded = {{24{sext & lane_b[7]}}, lane_b};
      end else if (size == SZ_HALF) begin
         loaded = {{16{sext & lane_h[15]}}, lane_h};
      end
   end

endmodule

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - two-port round-robin arbiter and access sequencer for the data RAM
module data_mem_ctrl
   import data_mem_ctrl_pkg::*;
#(
   parameter int RAM_ADDR_W = 11,
   parameter int MEM_LIMIT  = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  m0_req,
   input  logic                  m0_we,
   input  logic [1:0]            m0_size,
   input  logic                  m0_sext,
   input  logic [RAM_ADDR_W-1:0] m0_addr,
   input  logic [31:0]           m0_wdata,
   output logic [31:0]           m0_rdata,
   output logic                  m0_ack,
   output logic                  m0_err,
   output logic                  m0_stall,
   input  logic                  m1_req,
   input  logic                  m1_we,
   input  logic [1:0]            m1_size,
   input  logic                  m1_sext,
   input  logic [RAM_ADDR_W-1:0] m1_addr,
   input  logic [31:0]           m1_wdata,
   output logic [31:0]           m1_rdata,
   output logic                  m1_ack,
   output logic                  m1_err,
   output logic                  ram_ce,
   output logic                  ram_we,
   output logic [RAM_ADDR_W-1:0] ram_addr,
   output logic [31:0]           ram_wdata,
   input  logic [31:0]           ram_rdata
);

   state_t                state, state_d;
   logic                  last_grant, gnt_q, we_q, sext_q, err_q;
   logic [1:0]            size_q;
   logic [RAM_ADDR_W-1:0] addr_q;
   logic [31:0]           wdata_q;

   logic                  sel, grab, bad;
   logic                  cur_port, cur_we, cur_sext, cur_err;
   logic [1:0]            cur_size;
   logic [RAM_ADDR_W-1:0] cur_addr, word_addr;
   logic [31:0]           cur_wdata, merged, loaded;

   logic                  ram_ce_d, ram_we_d, m0_ack_d, m1_ack_d, m0_err_d, m1_err_d;
   logic [RAM_ADDR_W-1:0] ram_addr_d;
   logic [31:0]           ram_wdata_d, m0_rdata_d, m1_rdata_d;

   assign m0_stall = m0_req & ~m0_ack;

   // Round-robin pick; the transaction fields come live from the winner in IDLE, from the latch after
   always_comb begin
      sel = (m0_req && m1_req) ? ~last_grant : m1_req;
      if (state == ST_IDLE) begin
         cur_port  = sel;
         cur_we    = sel ? m1_we    : m0_we;
         cur_size  = sel ? m1_size  : m0_size;
         cur_sext  = sel ? m1_sext  : m0_sext;
         cur_addr  = sel ? m1_addr  : m0_addr;
         cur_wdata = sel ? m1_wdata : m0_wdata;
      end else begin
         cur_port  = gnt_q;
         cur_we    = we_q;
         cur_size  = size_q;
         cur_sext  = sext_q;
         cur_addr  = addr_q;
         cur_wdata = wdata_q;
      end
      bad = (cur_size == SZ_BAD)
         || (cur_size == SZ_HALF && cur_addr[0])
         || (cur_size == SZ_WORD && cur_addr[1:0] != 2'b00)
         || (32'(cur_addr) >= 32'(MEM_LIMIT));
      cur_err   = (state == ST_IDLE) ? bad : err_q;
      word_addr = {cur_addr[RAM_ADDR_W-1:2], 2'b00};
   end

   data_mem_ctrl_be_lane_unit u_be_lane_unit (
      .word       (ram_rdata),
      .store_data (cur_wdata),
      .size       (cur_size),
      .offset     (cur_addr[1:0]),
      .sext       (cur_sext),
      .merged     (merged),
      .loaded     (loaded)
   );

   // Next state, then the output values to register for the state being entered
   always_comb begin
      state_d     = state;
      grab        = 1'b0;
      ram_ce_d    = 1'b0;
      ram_we_d    = 1'b0;
      ram_addr_d  = ram_addr;
      ram_wdata_d = ram_wdata;
      m0_ack_d    = 1'b0;
      m1_ack_d    = 1'b0;
      m0_err_d    = 1'b0;
      m1_err_d    = 1'b0;
      m0_rdata_d  = m0_rdata;
      m1_rdata_d  = m1_rdata;
      case (state)
         ST_IDLE: begin
            if (m0_req || m1_req) begin
               grab = 1'b1;
               if (bad) begin
                  state_d = ST_RESP;
               end else if (cur_we && cur_size != SZ_WORD) begin
                  state_d = ST_RMW_RD;
               end else begin
                  state_d = ST_ACC;
               end
            end
         end
         ST_ACC:    state_d = ST_RESP;
         ST_RMW_RD: state_d = ST_RMW_WR;
         ST_RMW_WR: state_d = ST_RESP;
         ST_RESP:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
      case (state_d)
         ST_ACC: begin
            ram_ce_d   = 1'b1;
            ram_we_d   = cur_we;
            ram_addr_d = word_addr;
            if (cur_we) begin
               ram_wdata_d = cur_wdata;
            end
         end
         ST_RMW_RD: begin
            ram_ce_d   = 1'b1;
            ram_addr_d = word_addr;
         end
         ST_RMW_WR: begin
            ram_ce_d    = 1'b1;
            ram_we_d    = 1'b1;
            ram_addr_d  = word_addr;
            ram_wdata_d = merged;
         end
         ST_RESP: begin
            if (cur_port) begin
               m1_ack_d = 1'b1;
               m1_err_d = cur_err;
            end else begin
               m0_ack_d = 1'b1;
               m0_err_d = cur_err;
            end
            // Load data is only present on ram_rdata during the ACC cycle.
            if (state == ST_ACC && !cur_we) begin
               if (cur_port) begin
                  m1_rdata_d = loaded;
               end else begin
                  m0_rdata_d = loaded;
               end
            end
         end
         default: ;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_d;
      end
   end

   // Grant history and request latch, captured only when IDLE accepts a request
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant <= 1'b1;
         gnt_q      <= 1'b0;
         we_q       <= 1'b0;
         size_q     <= SZ_BYTE;
         sext_q     <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         err_q      <= 1'b0;
      end else if (grab) begin
         last_grant <= sel;
         gnt_q      <= sel;
         we_q       <= cur_we;
         size_q     <= cur_size;
         sext_q     <= cur_sext;
         addr_q     <= cur_addr;
         wdata_q    <= cur_wdata;
         err_q      <= bad;
      end
   end

   // Registered RAM strobes and port responses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ram_ce    <= 1'b0;
         ram_we    <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
         m0_ack    <= 1'b0;
         m1_ack    <= 1'b0;
         m0_err    <= 1'b0;
         m1_err    <= 1'b0;
         m0_rdata  <= '0;
         m1_rdata  <= '0;
      end else begin
         ram_ce    <= ram_ce_d;
         ram_we    <= ram_we_d;
         ram_addr  <= ram_addr_d;
         ram_wdata <= ram_wdata_d;
         m0_ack    <= m0_ack_d;
         m1_ack    <= m1_ack_d;
         m0_err    <= m0_err_d;
         m1_err    <= m1_err_d;
         m0_rdata  <= m0_rdata_d;
         m1_rdata  <= m1_rdata_d;
      end
   end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - scoreboard bench for the data RAM arbiter and access sequencer
module tb_data_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_req, m0_we, m0_sext, m0_ack, m0_err, m0_stall;
   logic [1:0]  m0_size;
   logic [10:0] m0_addr;
   logic [31:0] m0_wdata, m0_rdata;
   logic        m1_req, m1_we, m1_sext, m1_ack, m1_err;
   logic [1:0]  m1_size;
   logic [10:0] m1_addr;
   logic [31:0] m1_wdata, m1_rdata;
   logic        ram_ce, ram_we;
   logic [10:0] ram_addr;
   logic [31:0] ram_wdata, ram_rdata;
   logic [31:0] mem [0:511];

   typedef struct {
      int          port;
      bit          err;
      bit          load;
      logic [31:0] data;
   } exp_t;

   exp_t sbq [$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   assign ram_rdata = (ram_ce && !ram_we) ? mem[ram_addr[10:2]] : 32'h0;

   always @(posedge clk) begin
      if (ram_ce && ram_we) mem[ram_addr[10:2]] <= ram_wdata;
   end

   data_mem_ctrl #(.RAM_ADDR_W(11), .MEM_LIMIT(1024)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_sext(m0_sext),
      .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rdata(m0_rdata),
      .m0_ack(m0_ack), .m0_err(m0_err), .m0_stall(m0_stall),
      .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_sext(m1_sext),
      .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rdata(m1_rdata),
      .m1_ack(m1_ack), .m1_err(m1_err),
      .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic expect_resp(input int p, input bit err, input bit load, input logic [31:0] d);
      exp_t e;
      e.port = p;
      e.err  = err;
      e.load = load;
      e.data = d;
      sbq.push_back(e);
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (m0_ack || m1_ack) begin
            check("ack_onehot", 32'(m0_ack && m1_ack), 32'h0);
            if (sbq.size() == 0) begin
               check("ack_unexpected", 32'(sbq.size()), 32'h1);
            end else begin
               e = sbq.pop_front();
               check("ack_port", 32'(m1_ack), 32'(e.port));
               check("ack_err", 32'(m1_ack ? m1_err : m0_err), 32'(e.err));
               if (e.load && !e.err) check("rdata", m1_ack ? m1_rdata : m0_rdata, e.data);
            end
         end
      end
   endtask

   task automatic issue(input int p, input logic we, input logic [1:0] sz, input logic sx,
                        input logic [10:0] a, input logic [31:0] wd, input bit exp_err,
                        input logic [31:0] exp_rd, input int exp_lat, input bit keep, input bit push);
      int lat;
      bit got, seen_ce, stall_ok;
      if ((p == 0 ? m0_req : m1_req) == 1'b0) begin
         @(posedge clk);
         #1;
      end
      if (push) expect_resp(p, exp_err, !we, exp_rd);
      if (p == 0) begin
         m0_we = we; m0_size = sz; m0_sext = sx; m0_addr = a; m0_wdata = wd; m0_req = 1'b1;
      end else begin
         m1_we = we; m1_size = sz; m1_sext = sx; m1_addr = a; m1_wdata = wd; m1_req = 1'b1;
      end
      lat = 0; got = 1'b0; seen_ce = 1'b0; stall_ok = 1'b1;
      while (!got && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
         got = (p == 0) ? m0_ack : m1_ack;
         if (ram_ce) seen_ce = 1'b1;
         if (p == 0 && m0_stall != !got) stall_ok = 1'b0;
      end
      check($sformatf("latency_p%0d_addr%h", p, a), 32'(lat), 32'(exp_lat));
      if (p == 0) check("m0_stall", 32'(stall_ok), 32'h1);
      if (exp_err) check($sformatf("err_no_ce_addr%h", a), 32'(seen_ce), 32'h0);
      if (!keep) begin
         if (p == 0) m0_req = 1'b0; else m1_req = 1'b0;
      end
   endtask

   initial begin
      rst = 1'b1;
      m0_req = 0; m0_we = 0; m0_size = 0; m0_sext = 0; m0_addr = 0; m0_wdata = 0;
      m1_req = 0; m1_we = 0; m1_size = 0; m1_sext = 0; m1_addr = 0; m1_wdata = 0;
      fork
         monitor();
      join_none
      #12;
      check("rst_ram_ce", 32'(ram_ce), 32'h0);
      check("rst_ram_we", 32'(ram_we), 32'h0);
      check("rst_ram_addr", 32'(ram_addr), 32'h0);
      check("rst_ram_wdata", ram_wdata, 32'h0);
      check("rst_ack_err", 32'({m0_ack, m1_ack, m0_err, m1_err}), 32'h0);
      check("rst_m0_rdata", m0_rdata, 32'h0);
      check("rst_m1_rdata", m1_rdata, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // T1: word store then word load
      issue(0, 1, 2'b10, 0, 11'h010, 32'hDEADBEEF, 0, 32'h0, 2, 0, 1);
      issue(0, 0, 2'b10, 0, 11'h010, 32'h0, 0, 32'hDEADBEEF, 2, 0, 1);

      // T2: byte store as read-modify-write, then sub-word loads and stores
      issue(1, 1, 2'b00, 0, 11'h012, 32'h00000055, 0, 32'h0, 3, 0, 1);
      check("t2_ram_byte_merge", mem[9'h004], 32'hDEAD55EF);
      issue(1, 0, 2'b00, 1, 11'h011, 32'h0, 0, 32'hFFFFFFAD, 2, 0, 1);
      issue(0, 0, 2'b01, 0, 11'h012, 32'h0, 0, 32'h000055EF, 2, 0, 1);
      issue(0, 0, 2'b01, 1, 11'h010, 32'h0, 0, 32'hFFFFDEAD, 2, 0, 1);
      issue(1, 0, 2'b00, 0, 11'h013, 32'h0, 0, 32'h000000EF, 2, 0, 1);
      issue(1, 1, 2'b01, 0, 11'h012, 32'hFFFF1234, 0, 32'h0, 3, 0, 1);
      check("t2_ram_half_merge", mem[9'h004], 32'hDEAD1234);
      issue(0, 1, 2'b00, 0, 11'h010, 32'hFFFFFFA1, 0, 32'h0, 3, 0, 1);
      check("t2_ram_byte0_merge", mem[9'h004], 32'hA1AD1234);
      issue(0, 0, 2'b10, 1, 11'h010, 32'h0, 0, 32'hA1AD1234, 2, 0, 1);

      // Preload words for the contention test and the top in-range word
      for (int i = 0; i < 4; i++) begin
         issue(0, 1, 2'b10, 0, 11'(32'h100 + 4 * i), 32'hC0DE0000 | 32'(i), 0, 32'h0, 2, 0, 1);
      end
      issue(1, 1, 2'b10, 0, 11'h3FC, 32'h0BADF00D, 0, 32'h0, 2, 0, 1);
      issue(1, 0, 2'b10, 0, 11'h3FC, 32'h0, 0, 32'h0BADF00D, 2, 0, 1);

      // T3: both ports back-to-back, grants must alternate starting with m0
      for (int i = 0; i < 4; i++) begin
         expect_resp(0, 0, 1, 32'hC0DE0000 | 32'(i));
         expect_resp(1, 0, 1, 32'hC0DE0000 | 32'(3 - i));
      end
      fork
         begin
            for (int i = 0; i < 4; i++)
               issue(0, 0, 2'b10, 0, 11'(32'h100 + 4 * i), 32'h0, 0, 32'h0, (i == 0) ? 2 : 6, i < 3, 0);
         end
         begin
            for (int j = 0; j < 4; j++)
               issue(1, 0, 2'b10, 0, 11'(32'h10C - 4 * j), 32'h0, 0, 32'h0, (j == 0) ? 5 : 6, j < 3, 0);
         end
      join

      // T4: rejected accesses
      issue(0, 0, 2'b01, 0, 11'h013, 32'h0, 1, 32'h0, 1, 0, 1);
      issue(1, 1, 2'b10, 0, 11'h402, 32'h12345678, 1, 32'h0, 1, 0, 1);
      issue(0, 0, 2'b11, 0, 11'h020, 32'h0, 1, 32'h0, 1, 0, 1);
      issue(1, 0, 2'b00, 0, 11'h400, 32'h0, 1, 32'h0, 1, 0, 1);

      // T5: reset during the read half of a half-word store
      @(posedge clk);
      #1;
      m0_we = 1; m0_size = 2'b01; m0_sext = 0; m0_addr = 11'h100; m0_wdata = 32'h0000ABCD; m0_req = 1;
      @(posedge clk);
      #1;
      check("t5_ce_in_rmw_rd", 32'(ram_ce), 32'h1);
      #2 rst = 1'b1;
      #1;
      check("t5_async_ce_we", 32'({ram_ce, ram_we}), 32'h0);
      m0_req = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("t5_ram_unchanged", mem[9'h040], 32'hC0DE0000);
      check("t5_rdata_cleared", m0_rdata, 32'h0);
      expect_resp(0, 0, 1, 32'hC0DE0001);
      expect_resp(1, 0, 1, 32'hC0DE0002);
      fork
         issue(0, 0, 2'b10, 0, 11'h104, 32'h0, 0, 32'h0, 2, 0, 0);
         issue(1, 0, 2'b10, 0, 11'h108, 32'h0, 0, 32'h0, 5, 0, 0);
      join

      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_empty", 32'(sbq.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
